// File: rtl/multi_input_conditioner.sv
// Multi-channel input conditioner: synchronizer, counter debouncer, edge strobes
// and sticky, acknowledgeable event flags that are ORed into one interrupt line.
module multi_input_conditioner #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int WAITTIME    = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] noisysignal,
    input  logic [CHANNELS-1:0] rise_en,
    input  logic [CHANNELS-1:0] fall_en,
    input  logic [CHANNELS-1:0] ack,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge,
    output logic [CHANNELS-1:0] event_pending,
    output logic                irq
);

    localparam int CNT_W = $clog2(WAITTIME + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(WAITTIME);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_r    [CHANNELS];
    logic [CNT_W-1:0]       cnt_r     [CHANNELS];
    logic [CNT_W-1:0]       cnt_nxt_s [CHANNELS];
    logic [CHANNELS-1:0]    synced_s;
    logic [CHANNELS-1:0]    expire_s;
    logic [CHANNELS-1:0]    accept_rise_s;
    logic [CHANNELS-1:0]    accept_fall_s;
    logic [CHANNELS-1:0]    set_s;

    // Debounce decision per channel, using the pre-edge synchronized sample.
    always_comb begin
        synced_s      = '0;
        expire_s      = '0;
        accept_rise_s = '0;
        accept_fall_s = '0;
        set_s         = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt_s[i] = '0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            synced_s[i]      = sync_r[i][SYNC_STAGES-1];
            expire_s[i]      = (synced_s[i] != conditioned[i]) && (cnt_r[i] == WAIT_MAX);
            accept_rise_s[i] = expire_s[i] & synced_s[i];
            accept_fall_s[i] = expire_s[i] & ~synced_s[i];
            set_s[i]         = (accept_rise_s[i] & rise_en[i]) | (accept_fall_s[i] & fall_en[i]);
            // Any agreeing sample restarts the count, so short glitches never accumulate.
            if (synced_s[i] == conditioned[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (expire_s[i]) begin
                cnt_nxt_s[i] = '0;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Synchronizer chains and debounce counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_r[i] <= '0;
                cnt_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], noisysignal[i]};
                cnt_r[i]  <= cnt_nxt_s[i];
            end
        end
    end

    // Registered level, edge strobes and sticky flags; a set beats a coincident ack.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            conditioned   <= '0;
            positiveedge  <= '0;
            negativeedge  <= '0;
            event_pending <= '0;
        end else begin
            conditioned   <= conditioned ^ expire_s;
            positiveedge  <= accept_rise_s;
            negativeedge  <= accept_fall_s;
            event_pending <= set_s | (event_pending & ~ack);
        end
    end

    assign irq = |event_pending;

endmodule
